// File: rtl/mem_sequencer.sv
// Sequencer in front of the memory unit: turns one byte read/write request into
// the registered MAR/MBR/RAM-enable strobe sequence and returns a response pulse.
module mem_sequencer #(
  parameter int unsigned WAIT_CYCLES = 2
) (
  input  logic        i_clk,
  input  logic        i_rst_n,
  input  logic        i_req_valid,
  output logic        o_req_ready,
  input  logic        i_req_write,
  input  logic        i_req_zero_page,
  input  logic        i_req_part,
  input  logic [15:0] i_req_addr,
  input  logic [7:0]  i_req_wdata,
  output logic        o_rsp_valid,
  output logic [7:0]  o_rsp_rdata,
  output logic        o_zero_page,
  output logic        o_mem_part,
  output logic        o_mem_out,
  output logic        o_mem_in,
  output logic        o_reg_mbr_load,
  output logic        o_reg_mbr_word_dir,
  output logic        o_reg_mar_load,
  output logic [15:0] o_address,
  output logic [7:0]  o_data_out,
  output logic        o_data_oe,
  input  logic [7:0]  i_data_in
);

  localparam int unsigned AW = 16;
  localparam int unsigned DW = 8;
  localparam int unsigned CW = 4;
  localparam logic [CW-1:0] CNT_LOAD = CW'(WAIT_CYCLES - 1);

  generate
    if (WAIT_CYCLES < 1 || WAIT_CYCLES > 15) begin : g_bad_wait
      $error("mem_sequencer: WAIT_CYCLES must be in 1..15");
    end
  endgenerate

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD_MAR,
    S_LOAD_MBR,
    S_ACCESS,
    S_RECOVER
  } state_t;

  state_t          r_state, w_state_nxt;
  logic [CW-1:0]   r_cnt, w_cnt_nxt;
  logic            r_write, w_write_nxt;
  logic            r_req_ready, w_req_ready_nxt;
  logic            r_rsp_valid, w_rsp_valid_nxt;
  logic [DW-1:0]   r_rsp_rdata, w_rsp_rdata_nxt;
  logic            r_zero_page, w_zero_page_nxt;
  logic            r_mem_part, w_mem_part_nxt;
  logic            r_mem_out, w_mem_out_nxt;
  logic            r_mem_in, w_mem_in_nxt;
  logic            r_mbr_load, w_mbr_load_nxt;
  logic            r_mbr_dir, w_mbr_dir_nxt;
  logic            r_mar_load, w_mar_load_nxt;
  logic [AW-1:0]   r_address, w_address_nxt;
  logic [DW-1:0]   r_data_out, w_data_out_nxt;
  logic            r_data_oe, w_data_oe_nxt;

  // State and every output are registered so strobes change only on clock edges.
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      r_state     <= S_IDLE;
      r_cnt       <= '0;
      r_write     <= 1'b0;
      r_req_ready <= 1'b0;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= '0;
      r_zero_page <= 1'b1;
      r_mem_part  <= 1'b0;
      r_mem_out   <= 1'b1;
      r_mem_in    <= 1'b1;
      r_mbr_load  <= 1'b0;
      r_mbr_dir   <= 1'b1;
      r_mar_load  <= 1'b0;
      r_address   <= '0;
      r_data_out  <= '0;
      r_data_oe   <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_cnt       <= w_cnt_nxt;
      r_write     <= w_write_nxt;
      r_req_ready <= w_req_ready_nxt;
      r_rsp_valid <= w_rsp_valid_nxt;
      r_rsp_rdata <= w_rsp_rdata_nxt;
      r_zero_page <= w_zero_page_nxt;
      r_mem_part  <= w_mem_part_nxt;
      r_mem_out   <= w_mem_out_nxt;
      r_mem_in    <= w_mem_in_nxt;
      r_mbr_load  <= w_mbr_load_nxt;
      r_mbr_dir   <= w_mbr_dir_nxt;
      r_mar_load  <= w_mar_load_nxt;
      r_address   <= w_address_nxt;
      r_data_out  <= w_data_out_nxt;
      r_data_oe   <= w_data_oe_nxt;
    end
  end

  // Next state plus the output values that the next state must present.
  always_comb begin
    w_state_nxt     = r_state;
    w_cnt_nxt       = r_cnt;
    w_write_nxt     = r_write;
    w_address_nxt   = r_address;
    w_zero_page_nxt = r_zero_page;
    w_mem_part_nxt  = r_mem_part;
    w_data_out_nxt  = r_data_out;
    w_rsp_rdata_nxt = r_rsp_rdata;
    w_req_ready_nxt = 1'b0;
    w_rsp_valid_nxt = 1'b0;
    w_mar_load_nxt  = 1'b0;
    w_mbr_load_nxt  = 1'b0;
    w_mem_out_nxt   = 1'b1;
    w_mem_in_nxt    = 1'b1;
    w_mbr_dir_nxt   = 1'b1;
    w_data_oe_nxt   = 1'b0;

    case (r_state)
      S_IDLE: begin
        if (i_req_valid && r_req_ready) begin
          w_state_nxt     = S_LOAD_MAR;
          w_write_nxt     = i_req_write;
          w_address_nxt   = i_req_addr;
          w_zero_page_nxt = i_req_zero_page;
          w_mem_part_nxt  = i_req_part;
          w_data_out_nxt  = i_req_write ? i_req_wdata : '0;
          w_data_oe_nxt   = i_req_write;
          w_mar_load_nxt  = 1'b1;
        end else begin
          w_req_ready_nxt = 1'b1;
        end
      end
      S_LOAD_MAR: begin
        if (r_write) begin
          w_state_nxt    = S_LOAD_MBR;
          w_mbr_load_nxt = 1'b1;
          w_data_oe_nxt  = 1'b1;
        end else begin
          w_state_nxt    = S_ACCESS;
          w_cnt_nxt      = CNT_LOAD;
          w_mem_out_nxt  = 1'b0;
          w_mbr_dir_nxt  = 1'b0;
        end
      end
      S_LOAD_MBR: begin
        w_state_nxt  = S_ACCESS;
        w_cnt_nxt    = CNT_LOAD;
        w_mem_in_nxt = 1'b0;
      end
      S_ACCESS: begin
        if (r_cnt == '0) begin
          w_state_nxt     = S_RECOVER;
          w_rsp_valid_nxt = 1'b1;
          if (!r_write) begin
            w_rsp_rdata_nxt = i_data_in;
          end
        end else begin
          w_cnt_nxt = r_cnt - CW'(1);
          if (r_write) begin
            w_mem_in_nxt = 1'b0;
          end else begin
            w_mem_out_nxt = 1'b0;
            w_mbr_dir_nxt = 1'b0;
          end
        end
      end
      S_RECOVER: begin
        w_state_nxt     = S_IDLE;
        w_req_ready_nxt = 1'b1;
        w_cnt_nxt       = '0;
        w_address_nxt   = '0;
        w_zero_page_nxt = 1'b1;
        w_mem_part_nxt  = 1'b0;
        w_data_out_nxt  = '0;
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  assign o_req_ready        = r_req_ready;
  assign o_rsp_valid        = r_rsp_valid;
  assign o_rsp_rdata        = r_rsp_rdata;
  assign o_zero_page        = r_zero_page;
  assign o_mem_part         = r_mem_part;
  assign o_mem_out          = r_mem_out;
  assign o_mem_in           = r_mem_in;
  assign o_reg_mbr_load     = r_mbr_load;
  assign o_reg_mbr_word_dir = r_mbr_dir;
  assign o_reg_mar_load     = r_mar_load;
  assign o_address          = r_address;
  assign o_data_out         = r_data_out;
  assign o_data_oe          = r_data_oe;

endmodule

// File: tb/tb_mem_sequencer.sv
// Directed bench for mem_sequencer with a behavioural memory unit (MAR, MBR, RAM)
// on the strobe side and an always-on protocol monitor.
module tb_mem_sequencer;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic        req_valid = 1'b0, req_write = 1'b0, req_zp = 1'b1, req_part = 1'b0;
  logic [15:0] req_addr = '0;
  logic [7:0]  req_wdata = '0;
  logic [7:0]  data_in;
  logic        req_ready, rsp_valid, zero_page, mem_part, mem_out, mem_in;
  logic        mbr_load, mbr_dir, mar_load, data_oe;
  logic [7:0]  rsp_rdata, data_out;
  logic [15:0] address;

  mem_sequencer #(.WAIT_CYCLES(2)) u_dut (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(req_valid), .o_req_ready(req_ready),
    .i_req_write(req_write), .i_req_zero_page(req_zp), .i_req_part(req_part),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(rsp_valid),
    .o_rsp_rdata(rsp_rdata), .o_zero_page(zero_page), .o_mem_part(mem_part),
    .o_mem_out(mem_out), .o_mem_in(mem_in), .o_reg_mbr_load(mbr_load),
    .o_reg_mbr_word_dir(mbr_dir), .o_reg_mar_load(mar_load), .o_address(address),
    .o_data_out(data_out), .o_data_oe(data_oe), .i_data_in(data_in)
  );

  // Short and long wait builds share the request fields but have their own valids.
  logic        v1 = 1'b0, v15 = 1'b0;
  logic        rdy1, rsp1, mo1, mi1, rdy15, rsp15, mo15, mi15;
  logic        zp1, pt1, mbl1, dir1, mal1, oe1, zp15, pt15, mbl15, dir15, mal15, oe15;
  logic [7:0]  rd1, do1, rd15, do15;
  logic [15:0] ad1, ad15;

  mem_sequencer #(.WAIT_CYCLES(1)) u_w1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v1), .o_req_ready(rdy1),
    .i_req_write(req_write), .i_req_zero_page(req_zp), .i_req_part(req_part),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(rsp1),
    .o_rsp_rdata(rd1), .o_zero_page(zp1), .o_mem_part(pt1), .o_mem_out(mo1),
    .o_mem_in(mi1), .o_reg_mbr_load(mbl1), .o_reg_mbr_word_dir(dir1),
    .o_reg_mar_load(mal1), .o_address(ad1), .o_data_out(do1), .o_data_oe(oe1),
    .i_data_in(8'h5A)
  );

  mem_sequencer #(.WAIT_CYCLES(15)) u_w15 (
    .i_clk(clk), .i_rst_n(rst_n), .i_req_valid(v15), .o_req_ready(rdy15),
    .i_req_write(req_write), .i_req_zero_page(req_zp), .i_req_part(req_part),
    .i_req_addr(req_addr), .i_req_wdata(req_wdata), .o_rsp_valid(rsp15),
    .o_rsp_rdata(rd15), .o_zero_page(zp15), .o_mem_part(pt15), .o_mem_out(mo15),
    .o_mem_in(mi15), .o_reg_mbr_load(mbl15), .o_reg_mbr_word_dir(dir15),
    .o_reg_mar_load(mal15), .o_address(ad15), .o_data_out(do15), .o_data_oe(oe15),
    .i_data_in(8'hC3)
  );

  // Memory unit: MAR/MBR capture at the end of their strobe cycle, RAM written
  // on every edge that closes a cycle with mem_in low.
  logic [7:0]  ram [0:65535] = '{default: 8'h00};
  logic [15:0] mar_q = '0;
  logic [7:0]  mbr_q = '0;
  always @(posedge clk) begin
    if (!rst_n) ram[16'h1234] <= 8'hA5;
    if (mar_load) mar_q <= address;
    if (mbr_load) mbr_q <= data_oe ? data_out : 8'h00;
    if (!mem_in) ram[mar_q] <= mbr_q;
  end
  assign data_in = !mem_out ? ram[mar_q] : 8'h00;

  // Protocol invariants on every cycle once out of the initial reset.
  logic mon_en = 1'b0;
  int   inv_bad = 0;
  always @(negedge clk) begin
    if (mon_en) begin
      if ((mem_in === 1'b0 && mem_out === 1'b0) || (mbr_dir === 1'b0 && mem_out !== 1'b0) ||
          (data_oe === 1'b1 && mbr_dir === 1'b0) || (mar_load === 1'b1 && mbr_load === 1'b1)) begin
        inv_bad++;
        $display("FAIL invariant t=%0t mem_in=%b mem_out=%b dir=%b oe=%b mar=%b mbr=%b",
                 $time, mem_in, mem_out, mbr_dir, data_oe, mar_load, mbr_load);
      end
    end
  end

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Present a request at the falling edge and return just after the accept edge.
  task automatic start_txn(input logic wr, input logic zp, input logic part,
                           input logic [15:0] addr, input logic [7:0] wd);
    @(negedge clk);
    req_write = wr; req_zp = zp; req_part = part; req_addr = addr; req_wdata = wd;
    req_valid = 1'b1;
    check("ready_before_accept", req_ready, 1'b1);
    @(posedge clk);
    #1;
  endtask

  // Trace one transaction from its accept edge through the first IDLE cycle.
  task automatic watch_txn(input string tag, input logic wr, input logic zp, input logic part,
                           input logic [15:0] addr, input logic [7:0] wd, input logic [7:0] exp_rd);
    int lat = wr ? 5 : 4;
    int n_mar = 0, n_mbr = 0, n_out = 0, n_in = 0, n_rsp = 0, n_rdy = 0;
    int mar_k = 0, rsp_k = 0;
    logic [15:0] a_k = '0;
    logic [1:0]  zpp_k = '0;
    logic [7:0]  do_k = '0, rd = '0;
    logic        oe_k = 1'b0, rdy_last = 1'b0;
    for (int k = 1; k <= lat + 1; k++) begin
      @(negedge clk);
      if (mar_load) begin n_mar++; mar_k = k; a_k = address; zpp_k = {zero_page, mem_part}; end
      if (mbr_load) begin n_mbr++; do_k = data_out; oe_k = data_oe; end
      if (!mem_out) n_out++;
      if (!mem_in) n_in++;
      if (rsp_valid) begin n_rsp++; rsp_k = k; rd = rsp_rdata; end
      if (k <= lat && req_ready) n_rdy++;
      if (k == lat + 1) rdy_last = req_ready;
      @(posedge clk);
    end
    check({tag, "_mar_pulses"}, n_mar, 1);
    check({tag, "_mar_cycle"}, mar_k, 1);
    check({tag, "_address"}, a_k, addr);
    check({tag, "_zp_part"}, zpp_k, {zp, part});
    check({tag, "_mbr_pulses"}, n_mbr, wr ? 1 : 0);
    check({tag, "_enable_low"}, wr ? n_in : n_out, 2);
    check({tag, "_other_enable_low"}, wr ? n_out : n_in, 0);
    check({tag, "_rsp_pulses"}, n_rsp, 1);
    check({tag, "_rsp_latency"}, rsp_k, lat);
    check({tag, "_ready_busy"}, n_rdy, 0);
    check({tag, "_ready_idle"}, rdy_last, 1'b1);
    if (wr) begin
      check({tag, "_mbr_data"}, do_k, wd);
      check({tag, "_mbr_oe"}, oe_k, 1'b1);
    end else begin
      check({tag, "_rdata"}, rd, exp_rd);
    end
  endtask

  logic [7:0] shadow [0:15];

  initial begin
    // Reset held three edges with a request pending.
    rst_n = 1'b0; req_valid = 1'b1; req_write = 1'b1; req_addr = 16'hBEEF; req_wdata = 8'h99;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_addr", address, 16'h0000);
    check("rst_ctl", {req_ready, rsp_valid, zero_page, mem_part, mem_out, mem_in,
                      mbr_load, mbr_dir, mar_load, data_oe}, 10'b0010110100);
    check("rst_data", {rsp_rdata, data_out}, 16'h0000);
    rst_n = 1'b1; req_valid = 1'b0; mon_en = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("ready_after_release", req_ready, 1'b1);

    // Basic read and write, then read-back.
    start_txn(1'b0, 1'b1, 1'b0, 16'h1234, 8'h00);
    req_valid = 1'b0;
    watch_txn("rd1234", 1'b0, 1'b1, 1'b0, 16'h1234, 8'h00, 8'hA5);
    start_txn(1'b1, 1'b0, 1'b1, 16'h00FE, 8'h3C);
    req_valid = 1'b0;
    watch_txn("wr00fe", 1'b1, 1'b0, 1'b1, 16'h00FE, 8'h3C, 8'h00);
    start_txn(1'b0, 1'b1, 1'b0, 16'h00FE, 8'h00);
    req_valid = 1'b0;
    watch_txn("rd00fe", 1'b0, 1'b1, 1'b0, 16'h00FE, 8'h00, 8'h3C);

    // Valid held high: write, then a read queued behind it with wdata disturbed.
    start_txn(1'b1, 1'b1, 1'b0, 16'h0200, 8'h5C);
    req_write = 1'b0; req_wdata = 8'hFF;
    watch_txn("b2b_wr", 1'b1, 1'b1, 1'b0, 16'h0200, 8'h5C, 8'h00);
    #1 req_valid = 1'b0;
    watch_txn("b2b_rd", 1'b0, 1'b1, 1'b0, 16'h0200, 8'h00, 8'h5C);

    // Reset during the first write ACCESS cycle.
    start_txn(1'b1, 1'b1, 1'b0, 16'h0040, 8'h77);
    req_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("abort_in_access", mem_in, 1'b0);
    rst_n = 1'b0;
    @(negedge clk);
    check("abort_ctl", {mem_in, mem_out, mar_load, mbr_load, data_oe, rsp_valid, req_ready},
          7'b1100000);
    check("abort_addr", address, 16'h0000);
    rst_n = 1'b1;
    begin
      int n_rsp = 0;
      repeat (3) begin @(negedge clk); if (rsp_valid) n_rsp++; end
      check("abort_no_rsp", n_rsp, 0);
    end
    start_txn(1'b0, 1'b1, 1'b0, 16'h0040, 8'h00);
    req_valid = 1'b0;
    watch_txn("rd_after_abort", 1'b0, 1'b1, 1'b0, 16'h0040, 8'h00, 8'h77);

    // Random traffic over a 16-byte window; reads checked against requested writes.
    for (int i = 0; i < 16; i++) shadow[i] = 8'h00;
    for (int n = 0; n < 1000; n++) begin
      logic       wr;
      logic [3:0] idx;
      logic [7:0] wd, got;
      int         seen;
      wr = 1'($urandom_range(0, 1));
      idx = 4'($urandom_range(0, 15));
      wd = 8'($urandom);
      start_txn(wr, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), 16'h0100 + 16'(idx), wd);
      req_valid = 1'b0;
      seen = 0;
      got = '0;
      for (int k = 0; k < 25 && seen == 0; k++) begin
        @(negedge clk);
        if (rsp_valid) begin seen = 1; got = rsp_rdata; end
      end
      check("rand_rsp_seen", seen, 1);
      if (wr) shadow[idx] = wd;
      else check("rand_rdata", got, shadow[idx]);
    end

    // Shortest and longest enable windows, launched together.
    @(negedge clk);
    req_write = 1'b0; req_addr = 16'h0AAA; v1 = 1'b1; v15 = 1'b1;
    check("w1_ready", rdy1, 1'b1);
    check("w15_ready", rdy15, 1'b1);
    @(posedge clk);
    #1 v1 = 1'b0; v15 = 1'b0;
    begin
      int lo1 = 0, lo15 = 0, k1 = 0, k15 = 0;
      logic [7:0] r1 = '0, r15 = '0;
      for (int k = 1; k <= 20; k++) begin
        @(negedge clk);
        if (!mo1) lo1++;
        if (!mo15) lo15++;
        if (rsp1) begin k1 = k; r1 = rd1; end
        if (rsp15) begin k15 = k; r15 = rd15; end
      end
      check("w1_mem_out_low", lo1, 1);
      check("w15_mem_out_low", lo15, 15);
      check("w1_rsp_latency", k1, 3);
      check("w15_rsp_latency", k15, 17);
      check("w1_rdata", r1, 8'h5A);
      check("w15_rdata", r15, 8'hC3);
    end

    check("invariant_violations", inv_bad, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
